// File: rtl/instr_boot_loader_if.sv
// instr_boot_loader_if: byte-stream input and instruction-memory write port of the boot loader.
interface instr_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    modport master (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wdata);
    modport slave (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/instr_boot_loader.sv
// instr_boot_loader: loads a counted, XOR-checked LE byte image into imem and releases core reset once verified.
module instr_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_boot_loader_if.master   bus,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERROR} state_t;
    localparam logic [16:0] MAX_N = 17'(2 ** ADDR_WIDTH);
    localparam logic [31:0] T_LIM = 32'(TIMEOUT_CYCLES);
    state_t      state, state_d;
    logic [1:0]  err_d, bcnt;
    logic [15:0] cnt;
    logic [16:0] idx, cnt_n;
    logic [7:0]  csum;
    logic [31:0] word, tcnt;
    logic        loading, hs, restart, tout;
    assign loading       = state inside {HDR0, HDR1, DATA, CSUM};
    assign hs            = bus.rx_valid & loading;
    assign restart       = start & (state inside {IDLE, DONE, ERROR});
    assign cnt_n         = {1'b0, bus.rx_data, cnt[7:0]};
    // idle cycles are counted from the last handshake; WRITE neither counts nor clears
    assign tout          = (TIMEOUT_CYCLES != 0) && loading && !hs && (tcnt == T_LIM - 32'd1);
    assign bus.rx_ready  = loading;
    assign bus.imem_we   = state == WRITE;
    assign busy          = loading | (state == WRITE);
    assign done          = state == DONE;
    assign core_rst_n    = state == DONE;
    always_comb begin
        state_d = state;
        err_d   = error;
        case (state)
            IDLE, DONE, ERROR: if (start) begin
                state_d = HDR0;
                err_d   = 2'd0;
            end
            HDR0: if (hs) state_d = HDR1;
            HDR1: if (hs) begin
                state_d = (cnt_n == 17'd0 || cnt_n > MAX_N) ? ERROR : DATA;
                err_d   = (cnt_n == 17'd0 || cnt_n > MAX_N) ? 2'd1 : error;
            end
            DATA: if (hs && bcnt == 2'd3) state_d = WRITE;
            WRITE: state_d = (idx + 17'd1 == {1'b0, cnt}) ? CSUM : DATA;
            CSUM: if (hs) begin
                state_d = (csum == bus.rx_data) ? DONE : ERROR;
                err_d   = (csum == bus.rx_data) ? error : 2'd2;
            end
            default: ;
        endcase
        if (tout) begin
            state_d = ERROR;
            err_d   = 2'd3;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            error <= 2'd0;
        end else begin
            state <= state_d;
            error <= err_d;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            idx            <= '0;
            bcnt           <= '0;
            csum           <= '0;
            word           <= '0;
            tcnt           <= '0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            tcnt <= (restart || hs) ? '0 : loading ? tcnt + 32'd1 : tcnt;
            if (restart) begin
                idx  <= '0;
                bcnt <= '0;
                csum <= '0;
            end
            if (hs && state == HDR0) cnt[7:0] <= bus.rx_data;
            if (hs && state == HDR1) cnt[15:8] <= bus.rx_data;
            if (hs && state == DATA) begin
                word <= {bus.rx_data, word[31:8]};
                csum <= csum ^ bus.rx_data;
                bcnt <= bcnt + 2'd1;
            end
            if (hs && state == DATA && bcnt == 2'd3) begin
                bus.imem_addr  <= idx[ADDR_WIDTH-1:0];
                bus.imem_wdata <= {bus.rx_data, word[31:8]};
            end
            if (state == WRITE) idx <= idx + 17'd1;
        end
    end
endmodule

// File: tb/tb_instr_boot_loader.sv
// tb_instr_boot_loader: randomized image loads against a queue-based image model; a monitor scores every imem write.
module tb_instr_boot_loader;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       core_rst_n, busy, done;
    logic [1:0] error;
    int         compared = 0;
    int         mismatched = 0;
    bit         gappy = 1'b0;
    wr_t        sb[$];
    instr_boot_loader_if #(.ADDR_WIDTH(10)) bus();
    instr_boot_loader #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        wr_t w;
        if (bus.imem_we === 1'b1) begin
            chk("no_ready_in_write", 32'(bus.rx_ready), 32'd0);
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("write_addr", 32'(bus.imem_addr), 32'(w.a));
                chk("write_data", bus.imem_wdata, w.d);
            end
        end
    end
    // image model: pushes expected writes, returns bytes the loader will consume and the final error code
    task automatic model(input bq_t b, output int used, output logic [1:0] e);
        int         n;
        logic [7:0] x;
        wr_t        t;
        n = int'({b[1], b[0]});
        if (n == 0 || n > 1024) begin
            used = 2;
            e = 2'd1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            t.a = 10'(w);
            t.d = {b[4*w+5], b[4*w+4], b[4*w+3], b[4*w+2]};
            sb.push_back(t);
            for (int k = 2; k < 6; k++) x ^= b[4*w+k];
        end
        used = 3 + 4 * n;
        e = (b[2+4*n] == x) ? 2'd0 : 2'd2;
    endtask
    function automatic bq_t make_image(input int n, input bit good);
        bq_t        q;
        logic [7:0] x, r;
        x = 8'h00;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            r = 8'($urandom);
            x ^= r;
            q.push_back(r);
        end
        q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
        return q;
    endfunction
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] v);
        int k;
        k = 0;
        while (gappy && $urandom_range(0, 1) == 1 && k < 3) begin
            bus.rx_valid = 1'b0;
            bus.rx_data = 8'($urandom);
            start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data = v;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) break;
        end
        if (k >= 100) chk("ready_within_bound", 32'(k), 32'd0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask
    task automatic run(input string tag, input bq_t b);
        int         used;
        logic [1:0] e;
        model(b, used, e);
        pulse_start();
        for (int i = 0; i < used; i++) send_byte(b[i]);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
        end
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_done"}, 32'(done), 32'(e == 2'd0));
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(e == 2'd0));
        chk({tag, "_pending_writes"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask
    initial begin
        bq_t img, hdr;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h40, 8'h06, 8'h13, 8'h81, 8'h0f, 8'ha0, 8'he8};
        run("clean", img);
        img[10] = 8'he9;
        run("bad_csum", img);
        hdr = '{8'h00, 8'h00};
        run("count_zero", hdr);
        hdr = '{8'h01, 8'h04};
        run("count_over", hdr);
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h93);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("timeout_early_error", 32'(error), 32'd0);
        chk("timeout_early_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("timeout_error", 32'(error), 32'd3);
        chk("timeout_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("timeout_done", 32'(done), 32'd0);
        run("after_timeout", make_image(2, 1'b1));
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("midrst_we", 32'(bus.imem_we), 32'd0);
        chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
        chk("midrst_wdata", bus.imem_wdata, 32'd0);
        chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("midrst_flags", {28'd0, done, error, 1'b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gappy = 1'b1;
        for (int i = 0; i < 8; i++) run("random", make_image($urandom_range(1, 6), $urandom_range(0, 3) != 0));
        gappy = 1'b0;
        run("max_count", make_image(1024, 1'b1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1);
    end
endmodule
